// File: rtl/seq_alu.sv
// seq_alu: 8-bit ALU for jrb8; single-cycle logic/add/shift ops plus 8-step iterative MUL/MULH.
// Define SEQ_ALU_DIV_EN to build the iterative DIV/MOD path; otherwise opcodes 14/15 return 8'hFF with carry set.
module seq_alu (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] op,
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] result,
    output logic       carry,
    output logic       overflow,
    output logic       done,
    output logic       busy
);
    localparam logic [3:0] OP_ADD = 4'd0,  OP_ADC = 4'd1,  OP_SUB = 4'd2,  OP_SBC = 4'd3;
    localparam logic [3:0] OP_AND = 4'd4,  OP_OR  = 4'd5,  OP_XOR = 4'd6,  OP_NOT = 4'd7;
    localparam logic [3:0] OP_SHL = 4'd8,  OP_SHR = 4'd9,  OP_INC = 4'd10, OP_DEC = 4'd11;
    localparam logic [3:0] OP_MUL = 4'd12, OP_MULH = 4'd13, OP_DIV = 4'd14, OP_MOD = 4'd15;

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [1:0]  op_q;
    logic [7:0]  a_q;
    logic [15:0] p;
    logic [15:0] p_next;
    logic [8:0]  mul_sum;
    logic [7:0]  fin_result;
    logic        fin_carry;
    logic        is_iter;
`ifdef SEQ_ALU_DIV_EN
    logic [7:0]  b_q;
    logic [8:0]  div_sh;
    logic        div_ge;
    logic [7:0]  div_rem;
`endif

    // Packs {overflow, carry, result} for every op that completes in one cycle.
    function automatic logic [9:0] alu_single(input logic [3:0] f, input logic [7:0] x,
                                              input logic [7:0] y_in, input logic ci_in);
        logic [7:0]        y;
        logic              ci;
        logic              arith;
        logic [8:0]        s;
        logic [7:0]        r;
        logic              c;
        logic              v;
        logic signed [7:0] xs;
        logic signed [7:0] ys;
        logic signed [7:0] rs;
        y = 8'h00; ci = 1'b0; arith = 1'b0; r = 8'h00; c = 1'b0; v = 1'b0;
        case (f)
            OP_ADD:  begin y = y_in;  ci = 1'b0;  arith = 1'b1; end
            OP_ADC:  begin y = y_in;  ci = ci_in; arith = 1'b1; end
            OP_SUB:  begin y = ~y_in; ci = 1'b1;  arith = 1'b1; end
            OP_SBC:  begin y = ~y_in; ci = ci_in; arith = 1'b1; end
            OP_INC:  begin y = 8'h00; ci = 1'b1;  arith = 1'b1; end
            OP_DEC:  begin y = 8'hFF; ci = 1'b0;  arith = 1'b1; end
            OP_AND:  r = x & y_in;
            OP_OR:   r = x | y_in;
            OP_XOR:  r = x ^ y_in;
            OP_NOT:  r = ~x;
            OP_SHL:  begin r = {x[6:0], 1'b0}; c = x[7]; end
            OP_SHR:  begin r = {1'b0, x[7:1]}; c = x[0]; end
`ifdef SEQ_ALU_DIV_EN
            OP_MOD:  begin r = x; c = 1'b1; end  // only reached on divide by zero
`endif
            default: begin r = 8'hFF; c = 1'b1; end
        endcase
        if (arith) begin
            s  = {1'b0, x} + {1'b0, y} + {8'h00, ci};
            r  = s[7:0];
            c  = s[8];
            xs = $signed(x);
            ys = $signed(y);
            rs = $signed(s[7:0]);
            v  = ((xs < 0) == (ys < 0)) && ((rs < 0) != (xs < 0));
        end
        return {v, c, r};
    endfunction

    always_comb begin
        is_iter = (op == OP_MUL) || (op == OP_MULH);
`ifdef SEQ_ALU_DIV_EN
        if ((op == OP_DIV || op == OP_MOD) && b != 8'h00)
            is_iter = 1'b1;
`endif
    end

    // One shift-add (MUL) or restore-divide (DIV) step; p holds {hi/rem, lo/quotient}.
    always_comb begin
        mul_sum = {1'b0, p[15:8]} + (p[0] ? {1'b0, a_q} : 9'd0);
        p_next  = {mul_sum, p[7:1]};
`ifdef SEQ_ALU_DIV_EN
        div_sh  = {p[15:8], p[7]};
        div_ge  = div_sh >= {1'b0, b_q};
        div_rem = div_ge ? (div_sh[7:0] - b_q) : div_sh[7:0];
        if (op_q[1])
            p_next = {div_rem, p[6:0], div_ge};
`endif
        fin_result = op_q[0] ? p_next[15:8] : p_next[7:0];
        fin_carry  = op_q[1] ? 1'b0 : (p_next[15:8] != 8'h00);
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            a_q  <= a;
            op_q <= op[1:0];
            p    <= {8'h00, (op[1] ? a : b)};
`ifdef SEQ_ALU_DIV_EN
            b_q  <= b;
`endif
        end else if (state == RUN) begin
            p <= p_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 3'd0;
            result   <= 8'h00;
            carry    <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (is_iter) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            cnt   <= 3'd0;
                        end else begin
                            {overflow, carry, result} <= alu_single(op, a, b, cin);
                            done <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (cnt == 3'd7) begin
                        result   <= fin_result;
                        carry    <= fin_carry;
                        overflow <= 1'b0;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        cnt      <= 3'd0;
                        state    <= IDLE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu: single-cycle ops, iterative MUL/DIV timing, ignored restart, reset abort.
module tb_seq_alu;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] result;
    logic       carry;
    logic       overflow;
    logic       done;
    logic       busy;
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    seq_alu dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b), .cin(cin),
        .result(result), .carry(carry), .overflow(overflow), .done(done), .busy(busy)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic single(input string tag, input logic [3:0] o, input logic [7:0] x,
                          input logic [7:0] y, input logic c, input logic [7:0] er,
                          input logic ec, input logic ev);
        @(negedge clk);
        op = o; a = x; b = y; cin = c; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, ".result"}, 16'(result), 16'(er));
        chk({tag, ".carry"}, 16'(carry), 16'(ec));
        chk({tag, ".overflow"}, 16'(overflow), 16'(ev));
        chk({tag, ".done"}, 16'(done), 16'd1);
        chk({tag, ".busy"}, 16'(busy), 16'd0);
        @(negedge clk);
        chk({tag, ".done_once"}, 16'(done), 16'd0);
    endtask

    task automatic iter(input string tag, input logic [3:0] o, input logic [7:0] x,
                        input logic [7:0] y, input logic [7:0] er, input logic ec,
                        input bit disturb);
        int pulses;
        @(negedge clk);
        op = o; a = x; b = y; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("%s.busy%0d", tag, i), 16'(busy), 16'd1);
            chk($sformatf("%s.nodone%0d", tag, i), 16'(done), 16'd0);
            if (disturb && i == 2) begin
                start = 1'b1; op = 4'd0; a = 8'h03; b = 8'h03;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        chk({tag, ".result"}, 16'(result), 16'(er));
        chk({tag, ".carry"}, 16'(carry), 16'(ec));
        chk({tag, ".overflow"}, 16'(overflow), 16'd0);
        chk({tag, ".done"}, 16'(done), 16'd1);
        chk({tag, ".busy_end"}, 16'(busy), 16'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
        chk({tag, ".single_done"}, 16'(pulses), 16'd0);
        chk({tag, ".result_hold"}, 16'(result), 16'(er));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int pulses;
        logic [3:0] abort_op;
        rst = 1'b1; start = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00; cin = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("reset.result", 16'(result), 16'h00);
        chk("reset.carry", 16'(carry), 16'd0);
        chk("reset.overflow", 16'(overflow), 16'd0);
        chk("reset.done", 16'(done), 16'd0);
        chk("reset.busy", 16'(busy), 16'd0);

        single("add", 4'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        single("adc", 4'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        single("sub", 4'd2, 8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        single("sub_ov", 4'd2, 8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        single("sbc", 4'd3, 8'h10, 8'h01, 1'b0, 8'h0E, 1'b1, 1'b0);
        single("and", 4'd4, 8'hF0, 8'h3C, 1'b0, 8'h30, 1'b0, 1'b0);
        single("or", 4'd5, 8'hF0, 8'h3C, 1'b0, 8'hFC, 1'b0, 1'b0);
        single("xor", 4'd6, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b0, 1'b0);
        single("not", 4'd7, 8'h5A, 8'h00, 1'b0, 8'hA5, 1'b0, 1'b0);
        single("shl", 4'd8, 8'h81, 8'h00, 1'b0, 8'h02, 1'b1, 1'b0);
        single("shr", 4'd9, 8'h81, 8'h00, 1'b0, 8'h40, 1'b1, 1'b0);
        single("inc", 4'd10, 8'hFF, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
        single("dec", 4'd11, 8'h80, 8'h00, 1'b0, 8'h7F, 1'b1, 1'b1);

        iter("mul", 4'd12, 8'h10, 8'h20, 8'h00, 1'b1, 1'b0);
        iter("mulh", 4'd13, 8'h10, 8'h20, 8'h02, 1'b1, 1'b1);
        iter("mul_small", 4'd12, 8'h0F, 8'h0B, 8'hA5, 1'b0, 1'b0);

`ifdef SEQ_ALU_DIV_EN
        iter("div", 4'd14, 8'd200, 8'd7, 8'd28, 1'b0, 1'b0);
        iter("mod", 4'd15, 8'd200, 8'd7, 8'd4, 1'b0, 1'b0);
        single("mod_zero", 4'd15, 8'h33, 8'h00, 1'b0, 8'h33, 1'b1, 1'b0);
        abort_op = 4'd14;
`else
        single("div_off", 4'd14, 8'd200, 8'd7, 1'b0, 8'hFF, 1'b1, 1'b0);
        single("mod_off", 4'd15, 8'd200, 8'd7, 1'b0, 8'hFF, 1'b1, 1'b0);
        abort_op = 4'd12;
`endif
        single("div_zero", 4'd14, 8'h42, 8'h00, 1'b0, 8'hFF, 1'b1, 1'b0);

        // Abort an iterative op with rst on its fifth step.
        @(negedge clk);
        op = abort_op; a = 8'd200; b = 8'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("abort.busy", 16'(busy), 16'd1);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort.result", 16'(result), 16'h00);
        chk("abort.carry", 16'(carry), 16'd0);
        chk("abort.overflow", 16'(overflow), 16'd0);
        chk("abort.done", 16'(done), 16'd0);
        chk("abort.busy_clr", 16'(busy), 16'd0);
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done || busy) pulses++;
        end
        chk("abort.quiet", 16'(pulses), 16'd0);

        single("add_after", 4'd0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0);

        // rst and start on the same edge: start is dropped.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; op = 4'd0; a = 8'h05; b = 8'h05;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst_start.result", 16'(result), 16'h00);
        chk("rst_start.done", 16'(done), 16'd0);
        @(negedge clk);
        chk("rst_start.later", 16'(done), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
